// File: rtl/zacore_decode_if.sv
// Zacore fetch->decode->execute bundle: fetch request, hazard controls,
// writeback port and the decoded op presented to execute.
interface zacore_decode_if;

  logic        i_fd_valid;
  logic [31:0] i_fd_inst;
  logic [31:0] i_fd_pc;
  logic        o_stall_fetch;
  logic        i_stall;
  logic        i_invalidate;
  logic        i_wb_we;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_de_valid;
  logic [31:0] o_de_pc;
  logic [4:0]  o_de_opcode;
  logic [2:0]  o_de_funct3;
  logic        o_de_funct7b5;
  logic [4:0]  o_de_rs1;
  logic [4:0]  o_de_rs2;
  logic [4:0]  o_de_rd;
  logic [31:0] o_de_rs1_val;
  logic [31:0] o_de_rs2_val;
  logic [31:0] o_de_imm;
  logic        o_de_rd_we;
  logic        o_de_illegal;

  // Surrounding pipeline (fetch, hazard unit, writeback, execute)
  modport master (
    output i_fd_valid, i_fd_inst, i_fd_pc, i_stall, i_invalidate,
           i_wb_we, i_wb_rd, i_wb_data,
    input  o_stall_fetch, o_de_valid, o_de_pc, o_de_opcode, o_de_funct3,
           o_de_funct7b5, o_de_rs1, o_de_rs2, o_de_rd, o_de_rs1_val,
           o_de_rs2_val, o_de_imm, o_de_rd_we, o_de_illegal
  );

  // Decode stage itself
  modport slave (
    input  i_fd_valid, i_fd_inst, i_fd_pc, i_stall, i_invalidate,
           i_wb_we, i_wb_rd, i_wb_data,
    output o_stall_fetch, o_de_valid, o_de_pc, o_de_opcode, o_de_funct3,
           o_de_funct7b5, o_de_rs1, o_de_rs2, o_de_rd, o_de_rs1_val,
           o_de_rs2_val, o_de_imm, o_de_rd_we, o_de_illegal
  );

endinterface

// File: rtl/zacore_decode.sv
// Zacore RV32I decode stage: registers the fetched instruction, decodes
// fields and immediates, reads the 32x32 register file (written from
// writeback) and hands one decoded op per cycle to execute.
module zacore_decode #(
  parameter int WB_BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  zacore_decode_if.slave  bus
);

  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam bit BYPASS_EN = (WB_BYPASS != 0);

  // Register file storage; entry 0 is never written and never read
  logic [31:0] regs [0:31];

  // Combinational decode of the instruction currently offered by fetch
  logic [4:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [31:0] dec_imm;
  logic        dec_legal;
  logic        dec_rd_we;
  logic [31:0] dec_rs1_val;
  logic [31:0] dec_rs2_val;

  // Output registers
  logic        de_valid;
  logic [31:0] de_pc;
  logic [4:0]  de_opcode;
  logic [2:0]  de_funct3;
  logic        de_funct7b5;
  logic [4:0]  de_rs1;
  logic [4:0]  de_rs2;
  logic [4:0]  de_rd;
  logic [31:0] de_rs1_val;
  logic [31:0] de_rs2_val;
  logic [31:0] de_imm;
  logic        de_rd_we;
  logic        de_illegal;

  logic [31:0] inst;
  logic        wb_write;
  logic        hold_refresh_rs1;
  logic        hold_refresh_rs2;

  assign inst     = bus.i_fd_inst;
  assign wb_write = bus.i_wb_we && (bus.i_wb_rd != 5'd0);

  // Fetch must freeze whenever execute freezes us
  assign bus.o_stall_fetch = bus.i_stall;

  // Writeback port: x0 stays hardwired to zero by never being written
  always_ff @(posedge i_clk) begin
    if (wb_write) begin
      regs[bus.i_wb_rd] <= bus.i_wb_data;
    end
  end

  // Field extraction, legality, rd write-enable and immediate selection
  always_comb begin
    dec_opcode   = inst[6:2];
    dec_funct3   = inst[14:12];
    dec_funct7b5 = inst[30];
    dec_rs1      = inst[19:15];
    dec_rs2      = inst[24:20];
    dec_rd       = inst[11:7];
    dec_imm      = 32'd0;
    dec_legal    = 1'b0;
    dec_rd_we    = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (dec_opcode)
        OPC_LUI, OPC_AUIPC: begin
          dec_legal = 1'b1;
          dec_rd_we = 1'b1;
          dec_imm   = {inst[31:12], 12'b0};
        end
        OPC_JAL: begin
          dec_legal = 1'b1;
          dec_rd_we = 1'b1;
          dec_imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
        end
        OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
          dec_legal = 1'b1;
          dec_rd_we = 1'b1;
          dec_imm   = {{20{inst[31]}}, inst[31:20]};
        end
        OPC_OP: begin
          dec_legal = 1'b1;
          dec_rd_we = 1'b1;
          dec_imm   = 32'd0;
        end
        OPC_BRANCH: begin
          dec_legal = 1'b1;
          dec_imm   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
        end
        OPC_STORE: begin
          dec_legal = 1'b1;
          dec_imm   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end
        OPC_MISC_MEM, OPC_SYSTEM: begin
          dec_legal = 1'b1;
          dec_imm   = {{20{inst[31]}}, inst[31:20]};
        end
        default: begin
          dec_legal = 1'b0;
        end
      endcase
    end
    if (dec_rd == 5'd0) begin
      dec_rd_we = 1'b0;
    end
  end

  // Operand read with optional same-cycle forwarding from writeback
  always_comb begin
    dec_rs1_val = 32'd0;
    dec_rs2_val = 32'd0;
    if (dec_rs1 != 5'd0) begin
      if (BYPASS_EN && wb_write && (bus.i_wb_rd == dec_rs1)) begin
        dec_rs1_val = bus.i_wb_data;
      end else begin
        dec_rs1_val = regs[dec_rs1];
      end
    end
    if (dec_rs2 != 5'd0) begin
      if (BYPASS_EN && wb_write && (bus.i_wb_rd == dec_rs2)) begin
        dec_rs2_val = bus.i_wb_data;
      end else begin
        dec_rs2_val = regs[dec_rs2];
      end
    end
  end

  // A held op must see writes that land on its sources while it waits
  assign hold_refresh_rs1 = de_valid && wb_write && (bus.i_wb_rd == de_rs1);
  assign hold_refresh_rs2 = de_valid && wb_write && (bus.i_wb_rd == de_rs2);

  // Output pipeline register: flush beats stall, stall beats load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      de_valid    <= 1'b0;
      de_pc       <= 32'd0;
      de_opcode   <= 5'd0;
      de_funct3   <= 3'd0;
      de_funct7b5 <= 1'b0;
      de_rs1      <= 5'd0;
      de_rs2      <= 5'd0;
      de_rd       <= 5'd0;
      de_rs1_val  <= 32'd0;
      de_rs2_val  <= 32'd0;
      de_imm      <= 32'd0;
      de_rd_we    <= 1'b0;
      de_illegal  <= 1'b0;
    end else if (bus.i_invalidate) begin
      de_valid <= 1'b0;
    end else if (bus.i_stall) begin
      if (hold_refresh_rs1) begin
        de_rs1_val <= bus.i_wb_data;
      end
      if (hold_refresh_rs2) begin
        de_rs2_val <= bus.i_wb_data;
      end
    end else begin
      de_valid    <= bus.i_fd_valid;
      de_pc       <= bus.i_fd_pc;
      de_opcode   <= dec_opcode;
      de_funct3   <= dec_funct3;
      de_funct7b5 <= dec_funct7b5;
      de_rs1      <= dec_rs1;
      de_rs2      <= dec_rs2;
      de_rd       <= dec_rd;
      de_rs1_val  <= dec_rs1_val;
      de_rs2_val  <= dec_rs2_val;
      de_imm      <= dec_imm;
      de_rd_we    <= dec_rd_we && dec_legal;
      de_illegal  <= !dec_legal;
    end
  end

  assign bus.o_de_valid    = de_valid;
  assign bus.o_de_pc       = de_pc;
  assign bus.o_de_opcode   = de_opcode;
  assign bus.o_de_funct3   = de_funct3;
  assign bus.o_de_funct7b5 = de_funct7b5;
  assign bus.o_de_rs1      = de_rs1;
  assign bus.o_de_rs2      = de_rs2;
  assign bus.o_de_rd       = de_rd;
  assign bus.o_de_rs1_val  = de_rs1_val;
  assign bus.o_de_rs2_val  = de_rs2_val;
  assign bus.o_de_imm      = de_imm;
  assign bus.o_de_rd_we    = de_rd_we;
  assign bus.o_de_illegal  = de_illegal;

endmodule
